// File: rtl/a2d_rr_sched.sv
// Round-robin A2D conversion scheduler: one convert + one read SPI exchange per trigger,
// cycling left load cell, right load cell, steering pot and battery.
//
// state | meaning
// IDLE  | waiting for nxt or a pending request
// CNV   | conversion-start transaction in flight, waiting for done
// GAP   | one-cycle spacer before launching the read transaction
// RD    | read transaction in flight, capture rd_data on done
// CAP   | advance the round-robin pointer
module a2d_rr_sched #(
    parameter logic [2:0] CH_LFT   = 3'd0,
    parameter logic [2:0] CH_RGHT  = 3'd4,
    parameter logic [2:0] CH_STEER = 3'd5,
    parameter logic [2:0] CH_BATT  = 3'd6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        nxt,
    output logic        wrt,
    output logic [15:0] cmd,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] steer_pot,
    output logic [11:0] batt,
    output logic        upd,
    output logic        busy
);

    typedef enum logic [2:0] {IDLE, CNV, GAP, RD, CAP} state_t;

    state_t     state;
    logic [1:0] rr;
    logic       pend;
    logic [2:0] rr_ch;

    // Only the 12-bit conversion result is meaningful on the read-back.
    logic unused_rd_hi;
    assign unused_rd_hi = ^rd_data[15:12];

    always_comb begin
        rr_ch = CH_LFT;
        case (rr)
            2'd0: rr_ch = CH_LFT;
            2'd1: rr_ch = CH_RGHT;
            2'd2: rr_ch = CH_STEER;
            2'd3: rr_ch = CH_BATT;
            default: rr_ch = CH_LFT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr        <= 2'd0;
            pend      <= 1'b0;
            wrt       <= 1'b0;
            upd       <= 1'b0;
            busy      <= 1'b0;
            cmd       <= 16'h0000;
            lft_ld    <= 12'h000;
            rght_ld   <= 12'h000;
            steer_pot <= 12'h000;
            batt      <= 12'h000;
        end else begin
            wrt <= 1'b0;
            upd <= 1'b0;
            // A trigger during an exchange is remembered once and served at IDLE.
            if (state != IDLE && nxt)
                pend <= 1'b1;
            case (state)
                IDLE: begin
                    if (nxt || pend) begin
                        wrt   <= 1'b1;
                        pend  <= 1'b0;
                        busy  <= 1'b1;
                        cmd   <= {2'b00, rr_ch, 11'h000};
                        state <= CNV;
                    end
                end
                CNV: begin
                    if (done)
                        state <= GAP;
                end
                GAP: begin
                    wrt   <= 1'b1;
                    state <= RD;
                end
                RD: begin
                    if (done) begin
                        case (rr)
                            2'd0: lft_ld    <= rd_data[11:0];
                            2'd1: rght_ld   <= rd_data[11:0];
                            2'd2: steer_pot <= rd_data[11:0];
                            2'd3: batt      <= rd_data[11:0];
                            default: lft_ld <= rd_data[11:0];
                        endcase
                        upd   <= 1'b1;
                        state <= CAP;
                    end
                end
                CAP: begin
                    rr    <= rr + 2'd1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_a2d_rr_sched.sv
// Bench for a2d_rr_sched: SPI slave model plus a scoreboard of expected commands and
// captured results, with per-cycle protocol checks on wrt/upd/busy.
module tb_a2d_rr_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        nxt = 1'b0;
    logic        done = 1'b0;
    logic [15:0] rd_data = 16'h0000;
    logic        wrt, upd, busy;
    logic [15:0] cmd;
    logic [11:0] lft_ld, rght_ld, steer_pot, batt;

    a2d_rr_sched dut (
        .clk(clk), .rst_n(rst_n), .nxt(nxt), .wrt(wrt), .cmd(cmd), .done(done),
        .rd_data(rd_data), .lft_ld(lft_ld), .rght_ld(rght_ld), .steer_pot(steer_pot),
        .batt(batt), .upd(upd), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [11:0] data;
    } exp_t;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int upd_cnt = 0;
    int wrt_cnt = 0;
    int rd_done_cyc = 0;
    int wrt_cyc = 0;
    int spi_lat = 4;
    int kind = 0;            // 0 none/spurious, 1 convert done, 2 read done
    bit glitch_gap = 1'b0;
    bit nxt_on_rd = 1'b0;
    bit spur_req = 1'b0;
    int mdl_rr = 0;
    logic [11:0] mdl [4];
    logic [15:0] exp_cmd_q [$];
    logic [15:0] spi_data_q [$];
    exp_t        exp_q [$];

    function automatic logic [2:0] ch_of(input int i);
        case (i)
            0: return 3'd0;
            1: return 3'd4;
            2: return 3'd5;
            default: return 3'd6;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic push_exp(input logic [15:0] d);
        logic [15:0] c;
        exp_t e;
        c = {2'b00, ch_of(mdl_rr), 11'h000};
        exp_cmd_q.push_back(c);
        exp_cmd_q.push_back(c);
        spi_data_q.push_back(d);
        e.idx  = mdl_rr;
        e.data = d[11:0];
        exp_q.push_back(e);
        mdl_rr = (mdl_rr + 1) % 4;
    endtask

    task automatic clear_model();
        exp_cmd_q.delete();
        spi_data_q.delete();
        exp_q.delete();
        for (int i = 0; i < 4; i++) mdl[i] = 12'h000;
        mdl_rr = 0;
    endtask

    task automatic pulse_nxt();
        nxt = 1'b1;
        tick();
        nxt = 1'b0;
    endtask

    task automatic wait_upd(input int target);
        for (int i = 0; i < 300 && upd_cnt < target; i++) tick();
        n_cmp++;
        if (upd_cnt < target) begin
            n_err++;
            $display("FAIL upd_timeout: got %0d updates, required %0d", upd_cnt, target);
        end
    endtask

    task automatic wait_wrt(input int target);
        for (int i = 0; i < 300 && wrt_cnt < target; i++) tick();
        n_cmp++;
        if (wrt_cnt < target) begin
            n_err++;
            $display("FAIL wrt_timeout: got %0d wrt pulses, required %0d", wrt_cnt, target);
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300 && busy !== 1'b0; i++) tick();
        tick();
    endtask

    task automatic do_exchange(input logic [15:0] d);
        int u;
        u = upd_cnt;
        push_exp(d);
        pulse_nxt();
        wait_upd(u + 1);
        wait_idle();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        clear_model();
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
    endtask

    // SPI slave: answers every wrt with done after spi_lat cycles; odd transactions return data.
    task automatic spi_model();
        int          cnt = 0;
        bit          second = 1'b0;
        bit          fire = 1'b0;
        bit          glitch_now = 1'b0;
        bit          nxt_set = 1'b0;
        logic [15:0] c;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                cnt = 0; second = 1'b0; fire = 1'b0; glitch_now = 1'b0;
            end else if (wrt === 1'b1) begin
                wrt_cnt++;
                wrt_cyc = cyc;
                n_cmp++;
                if (exp_cmd_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_wrt: got cmd %h, required no transaction", cmd);
                end else begin
                    c = exp_cmd_q.pop_front();
                    if (cmd !== c) begin
                        n_err++;
                        $display("FAIL cmd: got %h, required %h", cmd, c);
                    end
                end
                cnt = spi_lat;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) fire = 1'b1;
            end
            #1;
            done = 1'b0;
            kind = 0;
            if (nxt_set) begin nxt = 1'b0; nxt_set = 1'b0; end
            if (glitch_now) begin done = 1'b1; glitch_now = 1'b0; end
            if (spur_req) begin done = 1'b1; spur_req = 1'b0; end
            if (fire) begin
                fire = 1'b0;
                done = 1'b1;
                if (second) begin
                    kind = 2;
                    rd_data = (spi_data_q.size() != 0) ? spi_data_q.pop_front() : 16'h0000;
                    if (nxt_on_rd) begin nxt = 1'b1; nxt_set = 1'b1; end
                end else begin
                    kind = 1;
                    rd_data = 16'hF5A5;
                    glitch_now = glitch_gap;
                end
                second = !second;
            end
        end
    endtask

    // Per-cycle checks; done seen here is the one the DUT consumed at this edge.
    task automatic monitor();
        bit   p_cnv = 1'b0;
        bit   p_rd = 1'b0;
        bit   p_wrt = 1'b0;
        logic exp_u;
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (!rst_n) begin
                p_cnv = 1'b0; p_rd = 1'b0; p_wrt = 1'b0;
            end else begin
                exp_u = (done === 1'b1 && kind == 2) ? 1'b1 : 1'b0;
                n_cmp++;
                if (upd !== exp_u) begin
                    n_err++;
                    $display("FAIL upd_timing: got %b, required %b at cycle %0d", upd, exp_u, cyc);
                end
                if (p_cnv) begin
                    n_cmp++;
                    if (wrt !== 1'b1) begin
                        n_err++;
                        $display("FAIL gap_wrt: got %b, required 1 at cycle %0d", wrt, cyc);
                    end
                end
                if (p_wrt) begin
                    n_cmp++;
                    if (wrt !== 1'b0) begin
                        n_err++;
                        $display("FAIL wrt_double: got %b, required 0 at cycle %0d", wrt, cyc);
                    end
                end
                if (p_rd) begin
                    n_cmp++;
                    if (busy !== 1'b0) begin
                        n_err++;
                        $display("FAIL idle_after_cap: got busy %b, required 0", busy);
                    end
                end
                if (upd === 1'b1) begin
                    upd_cnt++;
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_upd: got upd with no expected result");
                    end else begin
                        e = exp_q.pop_front();
                        mdl[e.idx] = e.data;
                    end
                end
                n_cmp++;
                if ({lft_ld, rght_ld, steer_pot, batt} !== {mdl[0], mdl[1], mdl[2], mdl[3]}) begin
                    n_err++;
                    $display("FAIL regs: got %h %h %h %h, required %h %h %h %h",
                             lft_ld, rght_ld, steer_pot, batt, mdl[0], mdl[1], mdl[2], mdl[3]);
                end
                if (done === 1'b1 && kind == 2) rd_done_cyc = cyc;
                p_cnv = (done === 1'b1 && kind == 1);
                p_rd  = (done === 1'b1 && kind == 2);
                p_wrt = (wrt === 1'b1);
            end
        end
    endtask

    task automatic test_reset();
        int w, u;
        rst_n = 1'b0;
        clear_model();
        repeat (3) tick();
        n_cmp++;
        if ({wrt, upd, busy, cmd, lft_ld, rght_ld, steer_pot, batt} !== 67'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b%b%b %h %h %h %h %h, required all 0",
                     wrt, upd, busy, cmd, lft_ld, rght_ld, steer_pot, batt);
        end
        rst_n = 1'b1;
        tick();
        w = wrt_cnt;
        u = upd_cnt;
        push_exp(16'h0ABC);
        pulse_nxt();
        n_cmp++;
        if ({busy, wrt} !== 2'b11) begin
            n_err++;
            $display("FAIL first_wrt: got busy %b wrt %b, required 1 1", busy, wrt);
        end
        wait_upd(u + 1);
        wait_idle();
        n_cmp++;
        if (wrt_cnt - w != 2 || upd_cnt - u != 1) begin
            n_err++;
            $display("FAIL reset_xact_count: got %0d wrt %0d upd, required 2 1", wrt_cnt - w, upd_cnt - u);
        end
        n_cmp++;
        if ({lft_ld, rght_ld, steer_pot, batt} !== {12'hABC, 12'h000, 12'h000, 12'h000}) begin
            n_err++;
            $display("FAIL reset_first_result: got %h %h %h %h, required abc 000 000 000",
                     lft_ld, rght_ld, steer_pot, batt);
        end
    endtask

    task automatic test_round_robin();
        logic [15:0] d [5];
        d = '{16'h1123, 16'h2456, 16'h3789, 16'hE9AB, 16'h0CDE};
        apply_reset();
        for (int i = 0; i < 5; i++) do_exchange(d[i]);
        n_cmp++;
        if ({lft_ld, rght_ld, steer_pot, batt} !== {12'hCDE, 12'h456, 12'h789, 12'h9AB}) begin
            n_err++;
            $display("FAIL rr_results: got %h %h %h %h, required cde 456 789 9ab",
                     lft_ld, rght_ld, steer_pot, batt);
        end
    endtask

    task automatic test_pending_collapse();
        int w, u, r0;
        w = wrt_cnt;
        u = upd_cnt;
        push_exp(16'h0321);
        pulse_nxt();
        repeat (2) tick();
        for (int i = 0; i < 3; i++) begin
            pulse_nxt();
            tick();
        end
        push_exp(16'h0654);
        wait_upd(u + 1);
        r0 = rd_done_cyc;
        wait_wrt(w + 3);
        // Read done consumed at edge k; the follow-up wrt is registered at edge k+2 (cycle B+3).
        n_cmp++;
        if (wrt_cyc - r0 != 2) begin
            n_err++;
            $display("FAIL pend_latency: got %0d edges, required 2", wrt_cyc - r0);
        end
        wait_upd(u + 2);
        wait_idle();
        repeat (30) tick();
        n_cmp++;
        if (wrt_cnt - w != 4 || upd_cnt - u != 2) begin
            n_err++;
            $display("FAIL pend_collapse: got %0d wrt %0d upd, required 4 2", wrt_cnt - w, upd_cnt - u);
        end
    endtask

    task automatic test_same_cycle();
        int w, u, r0;
        w = wrt_cnt;
        u = upd_cnt;
        nxt_on_rd = 1'b1;
        push_exp(16'h0A1A);
        push_exp(16'h0B2B);
        pulse_nxt();
        wait_upd(u + 1);
        nxt_on_rd = 1'b0;
        r0 = rd_done_cyc;
        wait_wrt(w + 3);
        n_cmp++;
        if (wrt_cyc - r0 != 2) begin
            n_err++;
            $display("FAIL same_cycle_latency: got %0d edges, required 2", wrt_cyc - r0);
        end
        wait_upd(u + 2);
        wait_idle();
        repeat (10) tick();
        n_cmp++;
        if (wrt_cnt - w != 4) begin
            n_err++;
            $display("FAIL same_cycle_count: got %0d wrt, required 4", wrt_cnt - w);
        end
    endtask

    task automatic test_spurious_done();
        int w, u;
        w = wrt_cnt;
        u = upd_cnt;
        spur_req = 1'b1;
        repeat (5) tick();
        n_cmp++;
        if (busy !== 1'b0 || wrt_cnt != w || upd_cnt != u) begin
            n_err++;
            $display("FAIL idle_done: got busy %b wrt %0d upd %0d, required 0 0 0",
                     busy, wrt_cnt - w, upd_cnt - u);
        end
        glitch_gap = 1'b1;
        do_exchange(16'h0BEE);
        glitch_gap = 1'b0;
        n_cmp++;
        if (wrt_cnt - w != 2 || upd_cnt - u != 1) begin
            n_err++;
            $display("FAIL gap_done: got %0d wrt %0d upd, required 2 1", wrt_cnt - w, upd_cnt - u);
        end
    endtask

    task automatic test_reset_mid();
        int w;
        w = wrt_cnt;
        push_exp(16'h0444);
        pulse_nxt();
        wait_wrt(w + 2);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, wrt, upd} !== 3'b000) begin
            n_err++;
            $display("FAIL async_reset: got busy %b wrt %b upd %b, required 0 0 0", busy, wrt, upd);
        end
        n_cmp++;
        if ({cmd, lft_ld, rght_ld, steer_pot, batt} !== 64'd0) begin
            n_err++;
            $display("FAIL reset_regs: got %h %h %h %h %h, required all 0",
                     cmd, lft_ld, rght_ld, steer_pot, batt);
        end
        clear_model();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        do_exchange(16'h0777);
        n_cmp++;
        if (lft_ld !== 12'h777) begin
            n_err++;
            $display("FAIL post_reset_lft: got %h, required 777", lft_ld);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) mdl[i] = 12'h000;
        fork
            monitor();
            spi_model();
        join_none
        test_reset();
        test_round_robin();
        test_pending_collapse();
        test_same_cycle();
        test_spurious_done();
        test_reset_mid();
        repeat (5) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
